switch_input_unit: RTL

SWITCH_INPUT_UNIT -- requirements
Module: switch_input_unit

---
 rtl/switch_input_unit_pkg.sv | 26 ++
 rtl/switch_input_unit_key_debounce.sv | 73 +++++++
 rtl/switch_input_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/switch_input_unit_pkg.sv
// Shared definitions for the IN-instruction switch input unit: FSM encoding and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package switch_input_unit_pkg;

  // A 500000-sample stable window is 10 ms at 50 MHz, long enough to ride out contact bounce.
  localparam int SIU_DEBOUNCE_CYCLES = 500000;

  // Default slide-switch bus width and the register-file write width it is zero-extended to.
  localparam int SIU_DATA_W = 15;
  localparam int SIU_REG_W  = 32;

  // Handshake with the user: wait for a press, then a release, then retire the IN instruction.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } siu_state_t;

  // The LED is lit whenever the unit is blocked on the user.
  function automatic logic siu_is_waiting(input siu_state_t st);
    return (st == WAIT_PRESS) || (st == WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/switch_input_unit_key_debounce.sv
// Synchronizes the raw push-button and filters bounce; emits one-cycle press/release pulses.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples, pulse registered with the level update.
// Backpressure: none; pulses are fire-and-forget and must be consumed the cycle they appear.
module key_debounce
  import switch_input_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SIU_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta;
  logic             key_sync;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             differ;
  logic             accept;

  // Two-flop synchronizer; resets to the released level so reset exit looks like an idle key.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  assign differ = (key_sync != level_q);
  assign accept = differ && (cnt_q == CNT_LAST);

  // Count consecutive disagreeing samples; any agreeing sample restarts the window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!differ || accept) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Adopt the synchronized level once it has been stable long enough, flagging the edge direction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= accept && !key_sync;
      release_q <= accept &&  key_sync;
      if (accept) begin
        level_q <= key_sync;
      end
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/switch_input_unit.sv
// Stalls an IN instruction until the user presses and releases the confirm key, then writes the switches.
// Latency: in_valid one cycle after the debounced release; in_data updated one cycle after the debounced press.
// Backpressure: drives stall to the core while in_req is high and the transfer is not yet in DONE.
module switch_input_unit
  import switch_input_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SIU_DEBOUNCE_CYCLES,
  parameter int DATA_W          = SIU_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_n,
  input  logic [DATA_W-1:0] switches,
  input  logic              in_req,
  output logic [31:0]       in_data,
  output logic              in_valid,
  output logic              stall,
  output logic              waiting
);

  siu_state_t           state_q;
  siu_state_t           state_d;
  logic [DATA_W-1:0]    sw_meta;
  logic [DATA_W-1:0]    sw_sync;
  logic [SIU_REG_W-1:0] in_data_q;
  logic [SIU_REG_W-1:0] capture_val;
  logic                 capture;
  logic                 key_level;
  logic                 key_press;
  logic                 key_release;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clock         (clock),
    .reset         (reset),
    .key_n         (key_n),
    .level         (key_level),
    .press_pulse   (key_press),
    .release_pulse (key_release)
  );

  // Two-flop synchronizer for the slide switches; individual bits may skew but settle long before a press is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  // Zero-extend the synchronized switch value to register width.
  always_comb begin
    capture_val             = '0;
    capture_val[DATA_W-1:0] = sw_sync;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping in_req while waiting abandons the transfer without a write.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_req) begin
          state_d = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        // A key already held on entry has no fresh press edge, so it needs a release first.
        if (!in_req) begin
          state_d = IDLE;
        end else if (key_press) begin
          capture = 1'b1;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        // Advance only once the filtered level itself reads released.
        if (!in_req) begin
          state_d = IDLE;
        end else if (key_release && key_level) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hold the last captured value until the next accepted press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_data_q <= '0;
    end else if (capture) begin
      in_data_q <= capture_val;
    end
  end

  assign in_data  = in_data_q;
  assign in_valid = (state_q == DONE);
  assign waiting  = siu_is_waiting(state_q);
  // Releasing the stall in DONE lets the PC advance in the same cycle the register write lands.
  assign stall    = reset && in_req && (state_q != DONE);

endmodule
